// File: rtl/snn_sched_pkg.sv
// Shared types and constants for the SNN timestep scheduler.
package snn_sched_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned STEP_COUNT_W = 16;

    // Scheduler FSM states; codes are visible on state_dbg.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_INTEG = 3'd2,
        ST_FIRE  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5,
        ST_CFG   = 3'd6
    } sched_state_e;

    // One-hot-ish strobe set decoded from the next state, registered as a group.
    typedef struct packed {
        logic latch;
        logic integ;
        logic fire;
        logic shift;
        logic done;
        logic busy;
        logic cfg_gnt;
    } sched_strobe_t;

    // True for the states that make up an active timestep.
    function automatic logic is_step_state(sched_state_e s);
        return (s == ST_LATCH) || (s == ST_INTEG) || (s == ST_FIRE) ||
               (s == ST_SHIFT) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/snn_tick_timer.sv
// Free-running timestep tick generator: one-cycle tick every TICK_PERIOD
// cycles while run_en is high; counter clears whenever run_en is low.
module snn_tick_timer #(
    parameter int unsigned TICK_PERIOD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Period counter with registered tick on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!run_en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// SNN timestep scheduler: sequences latch -> integrate sweep -> fire ->
// delay shift -> done per timestep, arbitrates the weight/delay memory with
// the configuration port, and flags lost ticks.
// Optional feature macro: SNN_SCHED_STATS_EN enables the completed-step counter.
module snn_timestep_scheduler
    import snn_sched_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned TICK_PERIOD = 16,
    localparam int unsigned IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_en,
    input  logic                    step_req,
    input  logic                    cfg_req,
    output logic                    cfg_gnt,
    output logic                    latch_inputs,
    output logic                    integ_en,
    output logic [IDX_W-1:0]        neuron_idx,
    output logic                    fire_en,
    output logic                    delay_shift,
    output logic                    step_done,
    output logic                    busy,
    output logic                    overrun,
    output logic [STATE_W-1:0]      state_dbg,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    // Reject parameter sets the sweep cannot fit into.
    if (TICK_PERIOD < NUM_NEURONS + 4) begin : g_bad_period
        $error("snn_timestep_scheduler: TICK_PERIOD must be >= NUM_NEURONS+4");
    end
    if (NUM_NEURONS < 2 || NUM_NEURONS > 64) begin : g_bad_neurons
        $error("snn_timestep_scheduler: NUM_NEURONS must be in 2..64");
    end

    sched_state_e    state;
    sched_state_e    state_next;
    sched_strobe_t   strb_next;
    logic [IDX_W-1:0] idx_next;
    logic            tick;
    logic            start_pending;
    logic            pending_next;
    logic            overrun_next;
    logic            req_arrive_c;

    snn_tick_timer #(
        .TICK_PERIOD (TICK_PERIOD)
    ) u_tick_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_en (run_en),
        .tick   (tick)
    );

    assign req_arrive_c = tick | step_req;
    assign state_dbg    = state;

    // Next state, next strobes and start/overrun bookkeeping.
    always_comb begin
        state_next   = state;
        idx_next     = '0;
        strb_next    = '0;
        pending_next = start_pending;
        overrun_next = overrun;

        case (state)
            ST_IDLE: begin
                // A request arriving this cycle blocks the grant so the timestep wins.
                if (start_pending) begin
                    state_next = ST_LATCH;
                end else if (cfg_req && !req_arrive_c) begin
                    state_next = ST_CFG;
                end
            end
            ST_LATCH: state_next = ST_INTEG;
            ST_INTEG: begin
                if (neuron_idx == IDX_LAST) begin
                    state_next = ST_FIRE;
                end else begin
                    idx_next = neuron_idx + IDX_W'(1);
                end
            end
            ST_FIRE:  state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            ST_CFG: begin
                if (!cfg_req) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase

        strb_next.latch   = (state_next == ST_LATCH);
        strb_next.integ   = (state_next == ST_INTEG);
        strb_next.fire    = (state_next == ST_FIRE);
        strb_next.shift   = (state_next == ST_SHIFT);
        strb_next.done    = (state_next == ST_DONE);
        strb_next.busy    = is_step_state(state_next);
        strb_next.cfg_gnt = (state_next == ST_CFG);

        // Pending request is consumed on the IDLE -> LATCH transition.
        if (req_arrive_c) begin
            pending_next = 1'b1;
        end else if (state == ST_IDLE && start_pending) begin
            pending_next = 1'b0;
        end

        if (!run_en) begin
            overrun_next = 1'b0;
        end else if (req_arrive_c && start_pending && state != ST_IDLE) begin
            overrun_next = 1'b1;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            start_pending <= 1'b0;
            overrun       <= 1'b0;
            neuron_idx    <= '0;
            latch_inputs  <= 1'b0;
            integ_en      <= 1'b0;
            fire_en       <= 1'b0;
            delay_shift   <= 1'b0;
            step_done     <= 1'b0;
            busy          <= 1'b0;
            cfg_gnt       <= 1'b0;
        end else begin
            state         <= state_next;
            start_pending <= pending_next;
            overrun       <= overrun_next;
            neuron_idx    <= idx_next;
            latch_inputs  <= strb_next.latch;
            integ_en      <= strb_next.integ;
            fire_en       <= strb_next.fire;
            delay_shift   <= strb_next.shift;
            step_done     <= strb_next.done;
            busy          <= strb_next.busy;
            cfg_gnt       <= strb_next.cfg_gnt;
        end
    end

`ifdef SNN_SCHED_STATS_EN
    // Completed-timestep counter, advancing as DONE is left; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
        end else if (state == ST_DONE) begin
            step_count <= step_count + STEP_COUNT_W'(1);
        end
    end
`else
    assign step_count = '0;
`endif

endmodule

// File: doc/snn_timestep_scheduler.md
SNN_TIMESTEP_SCHEDULER -- requirements
Module: snn_timestep_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8, the number of neurons swept per timestep (range 2..64).
REQ-002 SHALL have parameter TICK_PERIOD, default 16, the clock cycles between timestep ticks; elaboration SHALL fail if TICK_PERIOD < NUM_NEURONS+4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port run_en, input, 1 bit: free-running timestep enable.
REQ-006 SHALL have port step_req, input, 1 bit: single-cycle request for one timestep.
REQ-007 SHALL have port cfg_req, input, 1 bit: the SPI configuration logic requests the weight/delay memory.
REQ-008 SHALL have port cfg_gnt, output, 1 bit: configuration access is granted.
REQ-009 SHALL have port latch_inputs, output, 1 bit: capture input spikes.
REQ-010 SHALL have port integ_en, output, 1 bit: integrate the neuron at neuron_idx.
REQ-011 SHALL have port neuron_idx, output, $clog2(NUM_NEURONS) bits: index of the neuron being integrated.
REQ-012 SHALL have ports fire_en, delay_shift and step_done, outputs, 1 bit each: threshold/fire strobe, delay-line advance, and timestep complete.
REQ-013 SHALL have ports busy and overrun, outputs, 1 bit each: a timestep is in progress; a tick was lost.
REQ-014 SHALL have port state_dbg, output, 3 bits: current FSM state code, for debug_output.
REQ-015 SHALL have port step_count, output, 16 bits: completed timestep count.

Function
REQ-016 Tick timer SHALL count while run_en=1, raise tick every TICK_PERIOD cycles (first tick TICK_PERIOD cycles after run_en is first sampled high), and clear when run_en=0.
REQ-017 A tick or step_req SHALL set start_pending; setting it while already set and not consumed SHALL set overrun, which stays set until reset or run_en=0.
REQ-018 FSM states and codes SHALL be IDLE=0, LATCH=1, INTEG=2, FIRE=3, SHIFT=4, DONE=5, CFG=6.
REQ-019 From IDLE, start_pending=1 SHALL go to LATCH and clear start_pending; otherwise cfg_req=1 SHALL go to CFG; otherwise the FSM stays in IDLE.
REQ-020 When start_pending and cfg_req are both high in IDLE, the timestep SHALL win, and CFG SHALL be entered only after DONE returns the FSM to IDLE.
REQ-021 LATCH SHALL last 1 cycle with latch_inputs=1.
REQ-022 INTEG SHALL last NUM_NEURONS cycles with integ_en=1 and neuron_idx=0..NUM_NEURONS-1 in order; neuron_idx SHALL be 0 outside INTEG.
REQ-023 FIRE, SHIFT and DONE SHALL each last 1 cycle, strobing fire_en, delay_shift and step_done respectively.
REQ-024 busy SHALL be 1 in LATCH through DONE.
REQ-025 CFG SHALL hold cfg_gnt=1 while cfg_req=1, and SHALL return to IDLE the cycle after cfg_req falls.
REQ-026 Ticks arriving during CFG SHALL pend per REQ-017 and SHALL never preempt an active grant.
REQ-027 All strobes SHALL be registered (Moore outputs); no output SHALL be combinational from an input.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and drive every output to 0, including neuron_idx, overrun and step_count.
REQ-029 rst_n=0 SHALL also clear start_pending and the tick counter, including when asserted mid-INTEG or mid-CFG.

Configuration
REQ-030 With SNN_SCHED_STATS_EN defined, step_count SHALL increment by 1 in DONE, wrapping from 0xFFFF to 0.
REQ-031 Without SNN_SCHED_STATS_EN, step_count SHALL be tied to 0 and no counter SHALL be synthesized.

Structure
REQ-032 Package snn_sched_pkg SHALL hold the state enum, its 3-bit codes and the step_count width constant.
REQ-033 The tick timer SHALL be the sub-module snn_tick_timer.

Verification (NUM_NEURONS=8, TICK_PERIOD=16)
REQ-034 Reset check: rst_n low -> all outputs 0, state_dbg=0.
REQ-035 Free-running check: run_en=1 at cycle 0 -> latch_inputs at cycle 17, integ_en cycles 18-25 with idx 0..7, fire_en 26, delay_shift 27, step_done 28; next latch_inputs at cycle 33.
REQ-036 Config grant check: run_en=0, cfg_req high 5 cycles -> cfg_gnt high 5 cycles, starting 1 cycle after cfg_req; step_req during the grant -> LATCH 1 cycle after the grant ends.
REQ-037 Simultaneous-request check: cfg_req and step_req in the same IDLE cycle -> full timestep first, cfg_gnt=1 the cycle after IDLE is re-entered.
REQ-038 Overrun check: cfg_req held 40 cycles with run_en=1 -> overrun=1; one timestep follows the grant; run_en=0 clears overrun.
REQ-039 Mid-operation reset check: rst_n low in INTEG at idx 4 -> outputs 0 at once; no step_done after release; with SNN_SCHED_STATS_EN, step_count=0.
